alu_execute: RTL and testbench
==============================

# alu_execute

Execute stage of the TMVP accumulator pipeline, directly downstream of the operand-fetch stage. Each cycle it consumes the fetched 16-bit operand, load flag and 4-bit opcode, and updates a 16-bit accumulator plus carry/zero flags. The accumulator is presented as `alu_result` for register writeback. A 16-cycle shift-add multiplier stalls the upstream stages while it runs, and a sticky HALT freezes the stage.

## Interface

Parameters:
- `MUL_CYCLES`, 16: iterations of the multiplier; fixed at data width.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `value_in`  in  16  operand from operand fetch.
- `is_load_in`  in  1  load flag from operand fetch; forces LOAD regardless of opcode.
- `opcode_in`  in  4  opcode from operand fetch.
- `alu_result`  out  16  accumulator register, consumed by writeback.
- `carry`  out  1  carry/borrow flag.
- `zero`  out  1  zero flag.
- `stall`  out  1  multiplier busy; upstream must hold its outputs while high.
- `halted`  out  1  sticky halt indicator.

## Operation

- Reset (`rst`=0 at an edge) sets:
  - `alu_result`=0, `carry`=0, `zero`=1, `stall`=0, `halted`=0.
  - Multiplier counter and shift registers cleared.
- Inputs are accepted on every edge where `rst`=1, `stall`=0 and `halted`=0. Otherwise they are ignored.
- `is_load_in`=1 has priority over the opcode and acts as LOAD.
- Opcodes (acc = accumulator, v = value_in, all arithmetic mod 2^16):
  - 0 NOP: no change.
  - 1 LOAD: acc<=v; zero updated; carry unchanged.
  - 2 ADD: acc<=acc+v; carry=bit 16 of the 17-bit sum.
  - 3 SUB: acc<=acc-v; carry=1 iff acc<v (unsigned borrow).
  - 4 AND, 5 OR, 6 XOR: bitwise with v; carry<=0.
  - 7 NOT: acc<=~acc; carry<=0.
  - 8 SHL: acc<={acc[14:0],0}; carry<=acc[15].
  - 9 SHR: acc<={0,acc[15:1]}; carry<=acc[0].
  - 10 MUL: start multiplier with multiplicand=acc, multiplier=v.
  - 11 CMP: acc unchanged; zero<=(acc==v); carry<=(acc<v) unsigned.
  - 12 INC: acc<=acc+1; carry=1 iff acc was 0xFFFF.
  - 13 DEC: acc<=acc-1; carry=1 iff acc was 0x0000.
  - 14 STORE: no state change; acc remains on `alu_result` for writeback.
  - 15 HALT: `halted`<=1.
- Flag rules:
  - `zero` is recomputed from the new acc on every acc-writing opcode (1-10, 12, 13).
  - Opcodes 0, 14 and 15 leave both flags unchanged.
- Multiplier state machine, IDLE -> BUSY -> IDLE:
  - Unsigned 16x16 shift-add over a 32-bit product, one iteration per cycle, counter 0..MUL_CYCLES-1.
  - On completion: acc<=product[15:0]; carry<=|product[31:16] (overflow); zero from product[15:0].
- HALT is sticky until reset. Acc and flags are frozen; `stall` stays 0.

## Timing

- Single-cycle ops: result appears on `alu_result` and flags in the cycle after acceptance. Latency is 1, throughput 1 per cycle.
- MUL accepted at edge E:
  - `stall`=1 from E through E+16.
  - At edge E+16, acc/flags take the product and `stall` returns to 0.
  - The next instruction is accepted at edge E+17 at the earliest. Inputs presented during the stall are ignored.
- Back-to-back dependent ops need no forwarding: acc is internal.
- Reset during BUSY aborts the multiply. All outputs take reset values at that edge; no partial product is written.
- HALT accepted at edge E: `halted`=1 from E onward. An opcode presented together with HALT is just the HALT.

## Test plan

- Reset, then LOAD 0x1234 -> `alu_result`=0x1234 next cycle, `zero`=0; before the load, `zero`=1 and `alu_result`=0.
- LOAD 0xFFFF, ADD 0x0001 -> `alu_result`=0x0000, `carry`=1, `zero`=1; then SUB 0x0001 -> 0xFFFF, `carry`=1.
- LOAD 0x0300, MUL 0x0100 -> `stall` high exactly 16 cycles, then `alu_result`=0x0000, `carry`=1 (product 0x30000); LOAD 7, MUL 6 -> 0x002A, `carry`=0. Opcodes driven during the stall have no effect.
- LOAD 5, CMP 5 -> `zero`=1, `carry`=0, acc 5; CMP 6 -> `zero`=0, `carry`=1; SHR -> acc 2, `carry`=1.
- `is_load_in`=1 with `opcode_in`=ADD and value 0x00AA -> acc=0x00AA (load priority).
- HALT, then ADD 1 -> `halted`=1 and acc unchanged; reset mid-MUL (cycle 8) -> `stall`=0 and acc=0 at that edge, then normal operation resumes.

Source files
------------

// File: rtl/alu_execute.sv
// Accumulator execute stage: single-cycle ALU ops plus a 16-iteration shift-add multiplier.
// Latency 1 (MUL: 17); stall holds upstream while multiplying; HALT freezes the stage.
module alu_execute #(
  parameter int MUL_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value_in,
  input  logic        is_load_in,
  input  logic [3:0]  opcode_in,
  output logic [15:0] alu_result,
  output logic        carry,
  output logic        zero,
  output logic        stall,
  output logic        halted
);

  localparam int CW = $clog2(MUL_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(MUL_CYCLES - 1);

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,  OP_LOAD = 4'd1, OP_ADD = 4'd2,  OP_SUB = 4'd3,
    OP_AND = 4'd4,  OP_OR   = 4'd5, OP_XOR = 4'd6,  OP_NOT = 4'd7,
    OP_SHL = 4'd8,  OP_SHR  = 4'd9, OP_MUL = 4'd10, OP_CMP = 4'd11,
    OP_INC = 4'd12, OP_DEC  = 4'd13, OP_STORE = 4'd14, OP_HALT = 4'd15
  } op_t;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q;
  logic [15:0]   acc_q;
  logic          carry_q, zero_q, halted_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   mcand_q, prod_q;
  logic [15:0]   mplier_q;

  op_t         op;
  logic [15:0] acc_d;
  logic        carry_d, zero_d, halted_d;
  logic [16:0] sum17, diff17;
  logic [31:0] prod_d;

  always_comb begin
    op       = is_load_in ? OP_LOAD : op_t'(opcode_in);
    sum17    = {1'b0, acc_q} + {1'b0, value_in};
    diff17   = {1'b0, acc_q} - {1'b0, value_in};
    acc_d    = acc_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    halted_d = halted_q;
    case (op)
      OP_LOAD: acc_d = value_in;
      OP_ADD:  {carry_d, acc_d} = sum17;
      OP_SUB:  {carry_d, acc_d} = diff17;
      OP_AND:  begin acc_d = acc_q & value_in; carry_d = 1'b0; end
      OP_OR:   begin acc_d = acc_q | value_in; carry_d = 1'b0; end
      OP_XOR:  begin acc_d = acc_q ^ value_in; carry_d = 1'b0; end
      OP_NOT:  begin acc_d = ~acc_q;           carry_d = 1'b0; end
      OP_SHL:  begin acc_d = {acc_q[14:0], 1'b0}; carry_d = acc_q[15]; end
      OP_SHR:  begin acc_d = {1'b0, acc_q[15:1]}; carry_d = acc_q[0];  end
      OP_CMP:  carry_d = diff17[16];
      OP_INC:  begin acc_d = acc_q + 16'd1; carry_d = (acc_q == 16'hFFFF); end
      OP_DEC:  begin acc_d = acc_q - 16'd1; carry_d = (acc_q == 16'h0000); end
      OP_HALT: halted_d = 1'b1;
      default: ;
    endcase
    // CMP tests equality; MUL/NOP/STORE/HALT keep zero until the result is known
    case (op)
      OP_CMP: zero_d = (acc_q == value_in);
      OP_NOP, OP_MUL, OP_STORE, OP_HALT: ;
      default: zero_d = (acc_d == 16'h0000);
    endcase
    prod_d = prod_q + (mplier_q[0] ? mcand_q : 32'h0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      acc_q    <= 16'h0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b1;
      halted_q <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= 32'h0;
      mplier_q <= 16'h0;
      prod_q   <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!halted_q) begin
            acc_q    <= acc_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            halted_q <= halted_d;
            if (op == OP_MUL) begin
              state_q  <= BUSY;
              cnt_q    <= '0;
              mcand_q  <= {16'h0, acc_q};
              mplier_q <= value_in;
              prod_q   <= 32'h0;
            end
          end
        end
        BUSY: begin
          prod_q   <= prod_d;
          mcand_q  <= {mcand_q[30:0], 1'b0};
          mplier_q <= {1'b0, mplier_q[15:1]};
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_q <= IDLE;
            acc_q   <= prod_d[15:0];
            carry_q <= |prod_d[31:16];
            zero_q  <= (prod_d[15:0] == 16'h0000);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_result = acc_q;
  assign carry      = carry_q;
  assign zero       = zero_q;
  assign stall      = (state_q == BUSY);
  assign halted     = halted_q;

endmodule

// File: tb/tb_alu_execute.sv
// Scoreboard bench for alu_execute: a behavioural ISA model pushes expected state per instruction.
module tb_alu_execute;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value_in;
  logic        is_load_in;
  logic [3:0]  opcode_in;
  logic [15:0] alu_result;
  logic        carry, zero, stall, halted;

  typedef struct packed {
    logic [15:0] acc;
    logic        c;
    logic        z;
    logic        h;
  } exp_t;

  exp_t sb[$];
  exp_t exp;
  int checks = 0;
  int failures = 0;
  int scyc;

  logic [15:0] m_acc;
  logic        m_c, m_z, m_h;

  alu_execute #(.MUL_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .value_in(value_in), .is_load_in(is_load_in),
    .opcode_in(opcode_in), .alu_result(alu_result), .carry(carry),
    .zero(zero), .stall(stall), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic model(input logic ld, input logic [3:0] op, input logic [15:0] v);
    logic [3:0]  e;
    logic [31:0] r;
    e = ld ? 4'd1 : op;
    if (!m_h) begin
      case (e)
        4'd1:  begin m_acc = v; m_z = (v == 0); end
        4'd2:  begin r = 32'(m_acc) + 32'(v); m_acc = r[15:0]; m_c = r[16]; m_z = (m_acc == 0); end
        4'd3:  begin m_c = (m_acc < v); m_acc = m_acc - v; m_z = (m_acc == 0); end
        4'd4:  begin m_acc = m_acc & v; m_c = 0; m_z = (m_acc == 0); end
        4'd5:  begin m_acc = m_acc | v; m_c = 0; m_z = (m_acc == 0); end
        4'd6:  begin m_acc = m_acc ^ v; m_c = 0; m_z = (m_acc == 0); end
        4'd7:  begin m_acc = ~m_acc; m_c = 0; m_z = (m_acc == 0); end
        4'd8:  begin m_c = m_acc[15]; m_acc = m_acc << 1; m_z = (m_acc == 0); end
        4'd9:  begin m_c = m_acc[0]; m_acc = m_acc >> 1; m_z = (m_acc == 0); end
        4'd10: begin r = 32'(m_acc) * 32'(v); m_acc = r[15:0]; m_c = (r[31:16] != 0); m_z = (m_acc == 0); end
        4'd11: begin m_z = (m_acc == v); m_c = (m_acc < v); end
        4'd12: begin m_c = (m_acc == 16'hFFFF); m_acc = m_acc + 1; m_z = (m_acc == 0); end
        4'd13: begin m_c = (m_acc == 16'h0000); m_acc = m_acc - 1; m_z = (m_acc == 0); end
        4'd15: m_h = 1;
        default: ;
      endcase
    end
  endtask

  // Drive one instruction; for an accepted MUL, count stall cycles while junk is presented.
  task automatic issue(input logic ld, input logic [3:0] op, input logic [15:0] v,
                       output int stall_cycles);
    logic mul_go;
    mul_go = !m_h && !ld && (op == 4'd10);
    is_load_in = ld; opcode_in = op; value_in = v;
    model(ld, op, v);
    sb.push_back({m_acc, m_c, m_z, m_h});
    @(posedge clk); #1;
    stall_cycles = 0;
    if (mul_go) begin
      is_load_in = 1'b0; opcode_in = 4'd2; value_in = 16'hFFFF;
      while (stall === 1'b1 && stall_cycles < 40) begin
        stall_cycles++;
        opcode_in = 4'(stall_cycles % 16);
        @(posedge clk); #1;
      end
    end
    is_load_in = 1'b0; opcode_in = 4'd0; value_in = 16'h0;
  endtask

  task automatic do_reset();
    rst = 1'b0; is_load_in = 1'b0; opcode_in = 4'd0; value_in = 16'h0;
    @(posedge clk); #1;
    rst = 1'b1;
    m_acc = 0; m_c = 0; m_z = 1; m_h = 0;
    sb.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({alu_result, carry, zero, stall, halted} !== {16'h0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state: got acc=%h c=%b z=%b s=%b h=%b want acc=0000 c=0 z=1 s=0 h=0",
               alu_result, carry, zero, stall, halted);
    end
    issue(1'b0, 4'd1, 16'h1234, scyc);
    exp = sb.pop_front(); checks++;
    if ({alu_result, carry, zero, halted} !== exp) begin
      failures++; $display("FAIL load_1234: got %h want %h", {alu_result, carry, zero, halted}, exp);
    end
  endtask

  task automatic test_add_sub();
    logic [15:0] vs [5] = '{16'hFFFF, 16'h0001, 16'h0001, 16'h00F0, 16'h0F0F};
    logic [3:0]  os [5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd6};
    for (int i = 0; i < 5; i++) begin
      issue(1'b0, os[i], vs[i], scyc);
      exp = sb.pop_front(); checks++;
      if ({alu_result, carry, zero, halted} !== exp) begin
        failures++; $display("FAIL arith_step%0d: got %h want %h", i, {alu_result, carry, zero, halted}, exp);
      end
    end
  endtask

  task automatic test_misc_ops();
    logic [15:0] vs [9] = '{16'h8001, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'hFFFF, 16'h0, 16'h0};
    logic [3:0]  os [9] = '{4'd1, 4'd8, 4'd7, 4'd13, 4'd12, 4'd12, 4'd5, 4'd14, 4'd0};
    for (int i = 0; i < 9; i++) begin
      issue(1'b0, os[i], vs[i], scyc);
      exp = sb.pop_front(); checks++;
      if ({alu_result, carry, zero, halted} !== exp) begin
        failures++; $display("FAIL misc_step%0d: got %h want %h", i, {alu_result, carry, zero, halted}, exp);
      end
    end
  endtask

  task automatic test_mul();
    logic [15:0] vs [4] = '{16'h0300, 16'h0100, 16'h0007, 16'h0006};
    logic [3:0]  os [4] = '{4'd1, 4'd10, 4'd1, 4'd10};
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, os[i], vs[i], scyc);
      if (os[i] == 4'd10) begin
        checks++;
        if (scyc !== 16) begin
          failures++; $display("FAIL mul_stall_len%0d: got %0d want 16", i, scyc);
        end
      end
      exp = sb.pop_front(); checks++;
      if ({alu_result, carry, zero, halted} !== exp) begin
        failures++; $display("FAIL mul_step%0d: got %h want %h", i, {alu_result, carry, zero, halted}, exp);
      end
    end
  endtask

  task automatic test_cmp_shr();
    logic [15:0] vs [4] = '{16'd5, 16'd5, 16'd6, 16'd0};
    logic [3:0]  os [4] = '{4'd1, 4'd11, 4'd11, 4'd9};
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, os[i], vs[i], scyc);
      exp = sb.pop_front(); checks++;
      if ({alu_result, carry, zero, halted} !== exp) begin
        failures++; $display("FAIL cmp_step%0d: got %h want %h", i, {alu_result, carry, zero, halted}, exp);
      end
    end
  endtask

  task automatic test_load_priority();
    issue(1'b1, 4'd2, 16'h00AA, scyc);
    exp = sb.pop_front(); checks++;
    if ({alu_result, carry, zero, halted} !== exp) begin
      failures++; $display("FAIL load_priority: got %h want %h", {alu_result, carry, zero, halted}, exp);
    end
  endtask

  task automatic test_halt();
    issue(1'b0, 4'd15, 16'h0, scyc);
    exp = sb.pop_front(); checks++;
    if ({alu_result, carry, zero, halted} !== exp) begin
      failures++; $display("FAIL halt_set: got %h want %h", {alu_result, carry, zero, halted}, exp);
    end
    for (int i = 0; i < 3; i++) begin
      issue(i == 2, 4'd2, 16'h0001, scyc);
      exp = sb.pop_front(); checks++;
      if ({alu_result, carry, zero, stall, halted} !== {exp[18:1], 1'b0, exp[0]}) begin
        failures++; $display("FAIL halt_frozen%0d: got %h want %h", i, {alu_result, carry, zero, halted}, exp);
      end
    end
  endtask

  task automatic test_mul_reset();
    do_reset();
    issue(1'b0, 4'd1, 16'h0300, scyc);
    void'(sb.pop_front());
    is_load_in = 1'b0; opcode_in = 4'd10; value_in = 16'h0100;
    @(posedge clk); #1;
    opcode_in = 4'd0; value_in = 16'h0;
    repeat (7) @(posedge clk);
    #1; rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({alu_result, carry, zero, stall, halted} !== {16'h0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL mul_abort: got acc=%h c=%b z=%b s=%b h=%b want acc=0000 c=0 z=1 s=0 h=0",
               alu_result, carry, zero, stall, halted);
    end
    rst = 1'b1;
    m_acc = 0; m_c = 0; m_z = 1; m_h = 0;
    repeat (20) @(posedge clk);
    #1; checks++;
    if ({alu_result, stall} !== {16'h0, 1'b0}) begin
      failures++; $display("FAIL mul_abort_no_write: got acc=%h s=%b want acc=0000 s=0", alu_result, stall);
    end
    issue(1'b0, 4'd1, 16'h0055, scyc);
    issue(1'b0, 4'd2, 16'h0003, scyc);
    for (int i = 0; i < 2; i++) begin
      exp = sb.pop_front();
    end
    checks++;
    if ({alu_result, carry, zero, halted} !== exp) begin
      failures++; $display("FAIL resume_after_abort: got %h want %h", {alu_result, carry, zero, halted}, exp);
    end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_misc_ops();
    test_mul();
    test_cmp_shr();
    test_load_priority();
    test_halt();
    test_mul_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
